// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable frame format, majority-vote bit
// sampling, single-entry holding register, overrun and break handling.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RXD,
  input  logic                 RX_EN,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic                 RX_ACK,
  output logic [DATA_BITS-1:0] DQ,
  output logic                 RX_READY,
  output logic                 FRAME_ERROR,
  output logic                 PARITY_ERROR,
  output logic                 OVERRUN
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  logic                 rxd_meta;
  logic                 rxs;
  logic                 rxs_prev;
  logic                 armed;
  logic [2:0]           state;
  logic [DIV_WIDTH-1:0] presc;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bcnt;
  logic                 samp_lo;
  logic                 samp_mid;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;

  logic tick;
  logic start_det;
  logic decide;
  logic maj;
  logic complete;
  logic frame_err_new;
  logic parity_err_new;
  logic ack_ok;

  assign tick           = (presc == DIV);
  assign start_det      = (state == IDLE) && RX_EN && armed && rxs_prev && !rxs;
  assign decide         = tick && (scnt == S_HI) && (state != IDLE);
  assign maj            = majority3(samp_lo, samp_mid, rxs);
  assign complete       = decide && (state == STOP) && (bcnt == LAST_STOP);
  assign frame_err_new  = ferr_acc | ~maj;
  assign parity_err_new = PAR_EN ? (parity_of(shreg) ^ par_bit ^ PAR_ODD) : 1'b0;
  assign ack_ok         = RX_ACK && RX_READY;

  // Synchronizer, edge history and break arming; a break disarms until the line idles high
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      armed    <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxs      <= rxd_meta;
      rxs_prev <= rxs;
      if (complete && frame_err_new && !rxs) begin
        armed <= 1'b0;
      end else if (rxs) begin
        armed <= 1'b1;
      end
    end
  end

  // Tick prescaler and per-bit sample counter, both realigned to the start edge
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc <= {DIV_WIDTH{1'b0}};
      scnt  <= {SW{1'b0}};
    end else begin
      if (start_det || tick) begin
        presc <= {DIV_WIDTH{1'b0}};
      end else begin
        presc <= presc + DIV_WIDTH'(1);
      end
      if (start_det || (state == IDLE)) begin
        scnt <= {SW{1'b0}};
      end else if (tick) begin
        scnt <= (scnt == S_LAST) ? {SW{1'b0}} : scnt + SW'(1);
      end
    end
  end

  // Frame FSM: states advance at the third-sample majority decision of each bit
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      bcnt     <= {BW{1'b0}};
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
      shreg    <= {DATA_BITS{1'b0}};
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (!RX_EN) begin
      state <= IDLE;
      bcnt  <= {BW{1'b0}};
    end else if (state == IDLE) begin
      if (start_det) begin
        state    <= START;
        bcnt     <= {BW{1'b0}};
        ferr_acc <= 1'b0;
      end
    end else begin
      if (tick && (scnt == S_LO))  samp_lo  <= rxs;
      if (tick && (scnt == S_MID)) samp_mid <= rxs;
      if (decide) begin
        case (state)
          START: begin
            state <= maj ? IDLE : DATA;
            bcnt  <= {BW{1'b0}};
          end
          DATA: begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bcnt == LAST_DATA) begin
              bcnt  <= {BW{1'b0}};
              state <= PAR_EN ? PARITY : STOP;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
          PARITY: begin
            par_bit <= maj;
            bcnt    <= {BW{1'b0}};
            state   <= STOP;
          end
          STOP: begin
            if (bcnt == LAST_STOP) begin
              state <= IDLE;
            end else begin
              ferr_acc <= frame_err_new;
              bcnt     <= bcnt + BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Holding register: a completion coinciding with an accepted ack replaces the word
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DQ           <= {DATA_BITS{1'b0}};
      RX_READY     <= 1'b0;
      FRAME_ERROR  <= 1'b0;
      PARITY_ERROR <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      if (complete && (!RX_READY || RX_ACK)) begin
        DQ           <= shreg;
        FRAME_ERROR  <= frame_err_new;
        PARITY_ERROR <= parity_err_new;
        RX_READY     <= 1'b1;
      end else if (ack_ok) begin
        RX_READY <= 1'b0;
      end
      if (ack_ok) begin
        OVERRUN <= 1'b0;
      end else if (complete && RX_READY) begin
        OVERRUN <= 1'b1;
      end
    end
  end

endmodule
